// File: rtl/training_sample_sequencer.sv
// rtl/training_sample_sequencer.sv - sample table player feeding BackPropagationNN training runs
// Optional feature macro: EARLY_STOP_EN (adds y0/y1 inputs; a run ends at the first epoch where every sample matches)
module training_sample_sequencer #(
  parameter int DATA_W      = 9,
  parameter int NUM_SAMPLES = 4,
  parameter int HOLD_CYCLES = 9,
  parameter int EPOCHS      = 16,
  localparam int AW = $clog2(NUM_SAMPLES),
  localparam int EW = $clog2(EPOCHS) + 1,
  localparam int HW = $clog2(HOLD_CYCLES) + 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [4*DATA_W-1:0]      wr_x,
  input  logic [2*DATA_W-1:0]      wr_d,
  input  logic [AW:0]              num_active,
  input  logic                     start,
  input  logic                     abort,
`ifdef EARLY_STOP_EN
  input  logic                     y0,
  input  logic                     y1,
`endif
  output logic signed [DATA_W-1:0] x0,
  output logic signed [DATA_W-1:0] x1,
  output logic signed [DATA_W-1:0] x2,
  output logic signed [DATA_W-1:0] x3,
  output logic signed [DATA_W-1:0] desired_y0,
  output logic signed [DATA_W-1:0] desired_y1,
  output logic                     sample_valid,
  output logic                     new_sample,
  output logic [AW-1:0]            sample_idx,
  output logic [EW-1:0]            epoch_cnt,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic {IDLE, PLAY} state_t;

  localparam logic [AW:0]   N_MAX     = NUM_SAMPLES[AW:0];
  localparam int            HOLD_LAST = HOLD_CYCLES - 1;
  localparam logic [HW-1:0] HOLD_END  = HOLD_LAST[HW-1:0];
  localparam logic [EW-1:0] EPOCH_END = EPOCHS[EW-1:0];

  state_t state, state_next;

  logic [4*DATA_W-1:0] tab_x [NUM_SAMPLES];
  logic [2*DATA_W-1:0] tab_d [NUM_SAMPLES];

  logic [4*DATA_W-1:0] x_r;
  logic [2*DATA_W-1:0] d_r;
  logic [4*DATA_W-1:0] first_x;
  logic [2*DATA_W-1:0] first_d;
  logic [HW-1:0]       hold_cnt;
  logic [AW-1:0]       last_idx;
  logic [AW-1:0]       idx_next;
  logic [AW:0]         n_sel;
  logic [AW:0]         n_last;
  logic [EW-1:0]       epoch_inc;
  logic                last_hold;
  logic                stop_early;
  logic                load_first, advance, wrap, finish, clear;

  assign x0         = x_r[DATA_W-1:0];
  assign x1         = x_r[2*DATA_W-1:DATA_W];
  assign x2         = x_r[3*DATA_W-1:2*DATA_W];
  assign x3         = x_r[4*DATA_W-1:3*DATA_W];
  assign desired_y0 = d_r[DATA_W-1:0];
  assign desired_y1 = d_r[2*DATA_W-1:DATA_W];

  // Entry count is clamped to the table depth and stored as the last index of the epoch.
  assign n_sel     = (num_active > N_MAX) ? N_MAX : num_active;
  assign n_last    = n_sel - (AW+1)'(1);
  assign idx_next  = sample_idx + AW'(1);
  assign epoch_inc = epoch_cnt + EW'(1);
  assign last_hold = (hold_cnt == HOLD_END);

  // A write landing on entry 0 in the start cycle must be visible on the first presented sample.
  assign first_x = (wr_en && wr_addr == '0) ? wr_x : tab_x[0];
  assign first_d = (wr_en && wr_addr == '0) ? wr_d : tab_d[0];

`ifdef EARLY_STOP_EN
  logic epoch_ok;
  logic sample_ok;
  assign sample_ok  = (y0 == (desired_y0 != '0)) && (y1 == (desired_y1 != '0));
  assign stop_early = epoch_ok && sample_ok;
`else
  assign stop_early = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state decode: abort beats start and sequencing; the last hold cycle picks advance, wrap or finish.
  always_comb begin
    state_next = state;
    load_first = 1'b0;
    advance    = 1'b0;
    wrap       = 1'b0;
    finish     = 1'b0;
    clear      = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort && num_active != '0) begin
          state_next = PLAY;
          load_first = 1'b1;
        end
      end
      PLAY: begin
        if (abort) begin
          state_next = IDLE;
          clear      = 1'b1;
        end else if (last_hold) begin
          if (sample_idx == last_idx) begin
            if (epoch_inc == EPOCH_END || stop_early) begin
              state_next = IDLE;
              finish     = 1'b1;
            end else begin
              wrap = 1'b1;
            end
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Sample table: writable only while idle, never cleared by reset.
  always_ff @(posedge CLK) begin
    if (wr_en && state == IDLE) begin
      tab_x[wr_addr] <= wr_x;
      tab_d[wr_addr] <= wr_d;
    end
  end

  // Presentation datapath: registered outputs, hold counter, index and epoch bookkeeping.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      x_r          <= '0;
      d_r          <= '0;
      hold_cnt     <= '0;
      last_idx     <= '0;
      sample_idx   <= '0;
      epoch_cnt    <= '0;
      sample_valid <= 1'b0;
      new_sample   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifdef EARLY_STOP_EN
      epoch_ok     <= 1'b1;
`endif
    end else begin
      done       <= 1'b0;
      new_sample <= 1'b0;
      if (load_first) begin
        last_idx     <= n_last[AW-1:0];
        sample_idx   <= '0;
        hold_cnt     <= '0;
        epoch_cnt    <= '0;
        x_r          <= first_x;
        d_r          <= first_d;
        sample_valid <= 1'b1;
        new_sample   <= 1'b1;
        busy         <= 1'b1;
`ifdef EARLY_STOP_EN
        epoch_ok     <= 1'b1;
`endif
      end else if (clear || finish) begin
        x_r          <= '0;
        d_r          <= '0;
        hold_cnt     <= '0;
        sample_idx   <= '0;
        sample_valid <= 1'b0;
        busy         <= 1'b0;
        done         <= finish;
        epoch_cnt    <= finish ? epoch_inc : '0;
      end else if (wrap) begin
        sample_idx <= '0;
        hold_cnt   <= '0;
        epoch_cnt  <= epoch_inc;
        x_r        <= tab_x[0];
        d_r        <= tab_d[0];
        new_sample <= 1'b1;
`ifdef EARLY_STOP_EN
        epoch_ok   <= 1'b1;
`endif
      end else if (advance) begin
        sample_idx <= idx_next;
        hold_cnt   <= '0;
        x_r        <= tab_x[idx_next];
        d_r        <= tab_d[idx_next];
        new_sample <= 1'b1;
`ifdef EARLY_STOP_EN
        epoch_ok   <= epoch_ok && sample_ok;
`endif
      end else if (state == PLAY) begin
        hold_cnt <= hold_cnt + HW'(1);
      end
    end
  end

endmodule
